pu_riscv_biu_arb: RTL and testbench
===================================

PU_RISCV_BIU_ARB -- requirements
Module: pu_riscv_biu_arb

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width.
REQ-002 SHALL have parameter PLEN, default 64, physical address width.
REQ-003 SHALL have parameter DEPTH, default 2, max in-flight BIU transfers (power of 2, >=2).
REQ-004 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_stb_i  input  2  request strobe; index 0 = instruction side, index 1 = data side.
REQ-007 SHALL have port req_stb_ack_o  output  2  per-requester address-phase acknowledge.
REQ-008 SHALL have port req_adri_i  input  2xPLEN  request address.
REQ-009 SHALL have ports req_size_i, req_type_i, req_prot_i  input  2x3 each  size, burst type, protection.
REQ-010 SHALL have ports req_lock_i, req_we_i  input  2 each  locked-sequence flag, write enable.
REQ-011 SHALL have port req_d_i  input  2xXLEN  write data.
REQ-012 SHALL have ports req_q_o (output XLEN, shared read data), req_ack_o and req_err_o (output 2 each, per-requester data ack/error).
REQ-013 SHALL have BIU-side ports biu_stb_o, biu_adri_o, biu_size_o, biu_type_o, biu_lock_o, biu_prot_o, biu_we_o, biu_d_o (outputs); biu_stb_ack_i, biu_q_i, biu_ack_i, biu_err_i (inputs); widths as requester side.
REQ-014 SHALL have port spurious_o  output  1  one-cycle pulse on a BIU response with no transfer outstanding.

Function
REQ-015 SHALL select combinationally one requester (sel) each cycle; all biu_* address-phase outputs SHALL mirror req_*[sel].
REQ-016 Default priority: data (1) over instruction (0) when both strobe.
REQ-017 Starvation counter (2 bits): increments each cycle instruction strobes but is not acknowledged; at value 3 instruction wins next arbitration; cleared when req_stb_ack_o[0] asserts.
REQ-018 Lock: when biu_stb_ack_i accepts a transfer with biu_lock_o=1, lock_own <= sel and locked <= 1; while locked, sel = lock_own regardless of other strobe; locked clears on an accepted transfer of lock_own with lock=0.
REQ-019 biu_stb_o = req_stb_i[sel] & ~full, full = (count == DEPTH).
REQ-020 req_stb_ack_o[sel] = biu_stb_ack_i; the other bit SHALL be 0.
REQ-021 Owner FIFO, DEPTH entries x 1 bit: push sel on biu_stb_ack_i; pop on biu_ack_i | biu_err_i; count width $clog2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-022 Simultaneous push and pop: count unchanged, both pointers advance; pop SHALL read old head.
REQ-023 req_ack_o[head] = biu_ack_i and req_err_o[head] = biu_err_i when count != 0; all other bits 0; req_q_o = biu_q_i always.
REQ-024 Response with count == 0: no req_ack_o/req_err_o, no pop, spurious_o = 1 that cycle (registered flag not required; combinational pulse).
REQ-025 Error response SHALL pop like ack; it SHALL NOT clear locked.
REQ-026 Neither strobe and not locked: sel holds its previous value (registered last_sel) to keep outputs stable.

Reset
REQ-027 On rst_ni low: count, pointers, starvation counter, locked, lock_own, last_sel = 0; biu_stb_o, req_stb_ack_o, req_ack_o, req_err_o, spurious_o = 0 provided inputs idle.
REQ-028 Reset mid-transfer SHALL discard FIFO contents; later stray BIU responses produce spurious_o only.

Verification
REQ-029 Both strobe, biu_stb_ack_i=1 -> req_stb_ack_o=2'b10, FIFO head=1; biu_ack_i next -> req_ack_o=2'b10.
REQ-030 Data strobes continuously, instruction strobes 4 cycles unacked -> 5th arbitration grants instruction, req_stb_ack_o=2'b01, counter=0.
REQ-031 Instruction accepted with lock=1, then data strobes -> sel stays 0 until instruction transfer with lock=0 accepted.
REQ-032 DEPTH=2, two acks accepted, no response -> biu_stb_o=0 while count=2; ack with new strobe same cycle -> count stays 2.
REQ-033 Accept instr then data, respond err then ack -> req_err_o=2'b01 then req_ack_o=2'b10.
REQ-034 biu_ack_i with count=0 -> spurious_o=1, req_ack_o=2'b00, count remains 0.

Source files
------------

// File: rtl/pu_riscv_biu_arb_if.sv
// -----------------------------------------------------------------------------
// pu_riscv_biu_arb_if
// Bundles the requester-side and BIU-side signals of the BIU arbiter.
// Index 0 of every 2-wide requester field is the instruction side and index 1
// is the data side.
//   slave  : the arbiter's view (requests in, BIU address phase out,
//            BIU responses in, routed responses out)
//   master : the surrounding environment's view (mirror directions)
// Signal suffixes (_i/_o) are named from the arbiter's point of view.
// -----------------------------------------------------------------------------
interface pu_riscv_biu_arb_if #(
    parameter int XLEN = 64,
    parameter int PLEN = 64
);
    // requester side, address phase
    logic [1:0]                 req_stb_i;
    logic [1:0]                 req_stb_ack_o;
    logic [1:0][PLEN-1:0]       req_adri_i;
    logic [1:0][2:0]            req_size_i;
    logic [1:0][2:0]            req_type_i;
    logic [1:0][2:0]            req_prot_i;
    logic [1:0]                 req_lock_i;
    logic [1:0]                 req_we_i;
    logic [1:0][XLEN-1:0]       req_d_i;
    // requester side, data phase
    logic [XLEN-1:0]            req_q_o;
    logic [1:0]                 req_ack_o;
    logic [1:0]                 req_err_o;
    // BIU side, address phase
    logic                       biu_stb_o;
    logic                       biu_stb_ack_i;
    logic [PLEN-1:0]            biu_adri_o;
    logic [2:0]                 biu_size_o;
    logic [2:0]                 biu_type_o;
    logic                       biu_lock_o;
    logic [2:0]                 biu_prot_o;
    logic                       biu_we_o;
    logic [XLEN-1:0]            biu_d_o;
    // BIU side, data phase
    logic [XLEN-1:0]            biu_q_i;
    logic                       biu_ack_i;
    logic                       biu_err_i;
    // status
    logic                       spurious_o;

    modport slave (
        input  req_stb_i, req_adri_i, req_size_i, req_type_i, req_prot_i,
               req_lock_i, req_we_i, req_d_i,
               biu_stb_ack_i, biu_q_i, biu_ack_i, biu_err_i,
        output req_stb_ack_o, req_q_o, req_ack_o, req_err_o,
               biu_stb_o, biu_adri_o, biu_size_o, biu_type_o, biu_lock_o,
               biu_prot_o, biu_we_o, biu_d_o, spurious_o
    );

    modport master (
        output req_stb_i, req_adri_i, req_size_i, req_type_i, req_prot_i,
               req_lock_i, req_we_i, req_d_i,
               biu_stb_ack_i, biu_q_i, biu_ack_i, biu_err_i,
        input  req_stb_ack_o, req_q_o, req_ack_o, req_err_o,
               biu_stb_o, biu_adri_o, biu_size_o, biu_type_o, biu_lock_o,
               biu_prot_o, biu_we_o, biu_d_o, spurious_o
    );
endinterface

// File: rtl/pu_riscv_biu_arb.sv
// -----------------------------------------------------------------------------
// pu_riscv_biu_arb
// Arbitrates the instruction (0) and data (1) requesters onto a single
// pipelined BIU. The address phase is chosen combinationally each cycle; an
// owner FIFO remembers which requester each accepted transfer belongs to so
// that responses (which return in order) are routed back correctly.
// Ports:
//   clk_i  : clock, all state updates on the rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : requester and BIU signals (pu_riscv_biu_arb_if.slave)
// Parameters:
//   XLEN  : data width
//   PLEN  : physical address width
//   DEPTH : maximum in-flight BIU transfers (power of 2, >= 2)
// -----------------------------------------------------------------------------
module pu_riscv_biu_arb #(
    parameter int XLEN  = 64,
    parameter int PLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    pu_riscv_biu_arb_if.slave       bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    // state
    logic [1:0]         starv_q,    starv_d;
    logic               locked_q,   locked_d;
    logic               lock_own_q, lock_own_d;
    logic               last_sel_q, last_sel_d;
    logic [DEPTH-1:0]   fifo_q,     fifo_d;
    logic [AW-1:0]      wptr_q,     wptr_d;
    logic [AW-1:0]      rptr_q,     rptr_d;
    logic [CW-1:0]      count_q,    count_d;

    // combinational helpers
    logic               sel_s;
    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    logic               head_s;
    logic               rsp_s;
    logic [1:0]         stb_ack_s;
    logic [PLEN-1:0]    adri_s;
    logic [XLEN-1:0]    d_s;
    logic [XLEN-1:0]    q_s;

    assign full_s  = (count_q == CW'(DEPTH));
    assign empty_s = (count_q == {CW{1'b0}});
    assign head_s  = fifo_q[rptr_q];
    assign rsp_s   = bus.biu_ack_i | bus.biu_err_i;
    assign pop_s   = rsp_s & ~empty_s;
    // A full FIFO only takes a new owner when the head leaves in the same cycle.
    assign push_s  = bus.biu_stb_ack_i & (~full_s | pop_s);

    // Requester selection: lock owner, then starvation override, then data priority.
    always_comb begin
        sel_s = last_sel_q;
        if (locked_q) begin
            sel_s = lock_own_q;
        end else if (bus.req_stb_i == 2'b11) begin
            sel_s = (starv_q == 2'd3) ? 1'b0 : 1'b1;
        end else if (bus.req_stb_i[1]) begin
            sel_s = 1'b1;
        end else if (bus.req_stb_i[0]) begin
            sel_s = 1'b0;
        end else begin
            sel_s = last_sel_q;
        end
    end

    // Address-phase acknowledge goes only to the selected requester.
    always_comb begin
        stb_ack_s        = 2'b00;
        stb_ack_s[sel_s] = bus.biu_stb_ack_i;
    end

    assign adri_s = bus.req_adri_i[sel_s];
    assign d_s    = bus.req_d_i[sel_s];
    assign q_s    = bus.biu_q_i;

    assign bus.req_stb_ack_o = stb_ack_s;
    assign bus.biu_stb_o     = bus.req_stb_i[sel_s] & ~full_s;
    assign bus.biu_adri_o    = adri_s;
    assign bus.biu_size_o    = bus.req_size_i[sel_s];
    assign bus.biu_type_o    = bus.req_type_i[sel_s];
    assign bus.biu_lock_o    = bus.req_lock_i[sel_s];
    assign bus.biu_prot_o    = bus.req_prot_i[sel_s];
    assign bus.biu_we_o      = bus.req_we_i[sel_s];
    assign bus.biu_d_o       = d_s;
    assign bus.req_q_o       = q_s;
    // A response with nothing outstanding is flagged and otherwise ignored.
    assign bus.spurious_o    = rsp_s & empty_s;

    // Route the data-phase response to the owner at the FIFO head.
    always_comb begin
        bus.req_ack_o = 2'b00;
        bus.req_err_o = 2'b00;
        if (!empty_s) begin
            bus.req_ack_o[head_s] = bus.biu_ack_i;
            bus.req_err_o[head_s] = bus.biu_err_i;
        end else begin
            bus.req_ack_o = 2'b00;
            bus.req_err_o = 2'b00;
        end
    end

    // Next-state for starvation, lock tracking, last selection and owner FIFO.
    always_comb begin
        starv_d    = starv_q;
        locked_d   = locked_q;
        lock_own_d = lock_own_q;
        last_sel_d = sel_s;
        fifo_d     = fifo_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;

        // saturating counter of cycles the instruction side waits
        if (stb_ack_s[0]) begin
            starv_d = 2'd0;
        end else if (bus.req_stb_i[0] && (starv_q != 2'd3)) begin
            starv_d = starv_q + 2'd1;
        end else begin
            starv_d = starv_q;
        end

        // lock is set/cleared only by accepted transfers; error responses never touch it
        if (push_s) begin
            if (bus.biu_lock_o) begin
                locked_d   = 1'b1;
                lock_own_d = sel_s;
            end else if (locked_q && (sel_s == lock_own_q)) begin
                locked_d = 1'b0;
            end else begin
                locked_d = locked_q;
            end
        end else begin
            locked_d = locked_q;
        end

        if (push_s) begin
            fifo_d[wptr_q] = sel_s;
            wptr_d         = wptr_q + AW'(1);
        end else begin
            wptr_d = wptr_q;
        end

        if (pop_s) begin
            rptr_d = rptr_q + AW'(1);
        end else begin
            rptr_d = rptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with asynchronous reset; reset discards in-flight owners.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starv_q    <= 2'd0;
            locked_q   <= 1'b0;
            lock_own_q <= 1'b0;
            last_sel_q <= 1'b0;
            fifo_q     <= {DEPTH{1'b0}};
            wptr_q     <= {AW{1'b0}};
            rptr_q     <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
        end else begin
            starv_q    <= starv_d;
            locked_q   <= locked_d;
            lock_own_q <= lock_own_d;
            last_sel_q <= last_sel_d;
            fifo_q     <= fifo_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
        end
    end
endmodule

// File: tb/tb_pu_riscv_biu_arb.sv
// -----------------------------------------------------------------------------
// tb_pu_riscv_biu_arb
// Directed bench for the BIU arbiter. Inputs change 1 ns after the rising
// edge; combinational outputs are compared on the falling edge.
// Requester addresses are distinct (instr 0x1000, data 0x2000) so the
// selected requester is visible on biu_adri_o.
// -----------------------------------------------------------------------------
module tb_pu_riscv_biu_arb;
    localparam int XLEN  = 64;
    localparam int PLEN  = 64;
    localparam int DEPTH = 2;

    localparam logic [63:0] A_I = 64'h0000_0000_0000_1000;
    localparam logic [63:0] A_D = 64'h0000_0000_0000_2000;
    localparam logic [63:0] QV  = 64'hDEAD_BEEF_CAFE_F00D;

    logic clk_i;
    logic rst_ni;
    int   checks;
    int   failures;

    pu_riscv_biu_arb_if #(.XLEN(XLEN), .PLEN(PLEN)) bus ();

    pu_riscv_biu_arb #(.XLEN(XLEN), .PLEN(PLEN), .DEPTH(DEPTH)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic [1:0] stb, input logic [1:0] lck,
                       input logic sack, input logic ack, input logic err);
        bus.req_stb_i     = stb;
        bus.req_lock_i    = lck;
        bus.biu_stb_ack_i = sack;
        bus.biu_ack_i     = ack;
        bus.biu_err_i     = err;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_ni   = 1'b0;
        bus.req_adri_i[0] = A_I;
        bus.req_adri_i[1] = A_D;
        bus.req_size_i[0] = 3'b010;
        bus.req_size_i[1] = 3'b011;
        bus.req_type_i    = '0;
        bus.req_prot_i    = '0;
        bus.req_we_i      = 2'b10;
        bus.req_d_i[0]    = 64'h1111;
        bus.req_d_i[1]    = 64'h2222;
        bus.biu_q_i       = QV;
        drv(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // reset state with idle inputs
        @(negedge clk_i);
        chk("rst_biu_stb",  64'(bus.biu_stb_o),     64'd0);
        chk("rst_stb_ack",  64'(bus.req_stb_ack_o), 64'd0);
        chk("rst_ack",      64'(bus.req_ack_o),     64'd0);
        chk("rst_err",      64'(bus.req_err_o),     64'd0);
        chk("rst_spurious", 64'(bus.spurious_o),    64'd0);
        chk("rst_sel0",     bus.biu_adri_o,         A_I);
        tick();
        rst_ni = 1'b1;

        // both strobe: data wins, then its response is routed to data
        drv(2'b11, 2'b00, 1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("both_stb_ack", 64'(bus.req_stb_ack_o), 64'd2);
        chk("both_adri",    bus.biu_adri_o,         A_D);
        chk("both_size",    64'(bus.biu_size_o),    64'd3);
        chk("both_we",      64'(bus.biu_we_o),      64'd1);
        chk("both_biu_stb", 64'(bus.biu_stb_o),     64'd1);
        tick();
        drv(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        @(negedge clk_i);
        chk("both_ack",      64'(bus.req_ack_o),  64'd2);
        chk("both_q",        bus.req_q_o,         QV);
        chk("both_nospur",   64'(bus.spurious_o), 64'd0);
        chk("hold_last_sel", bus.biu_adri_o,      A_D);
        chk("idle_biu_stb",  64'(bus.biu_stb_o),  64'd0);
        tick();

        // response with nothing outstanding, twice (count stays 0)
        drv(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        @(negedge clk_i);
        chk("spur1",     64'(bus.spurious_o), 64'd1);
        chk("spur1_ack", 64'(bus.req_ack_o),  64'd0);
        tick();
        @(negedge clk_i);
        chk("spur2",     64'(bus.spurious_o), 64'd1);
        chk("spur2_ack", 64'(bus.req_ack_o),  64'd0);
        tick();

        // locked instruction sequence; error response keeps the lock
        drv(2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("lk_stb_ack", 64'(bus.req_stb_ack_o), 64'd1);
        chk("lk_lock_o",  64'(bus.biu_lock_o),    64'd1);
        tick();
        drv(2'b11, 2'b00, 1'b0, 1'b0, 1'b1);
        @(negedge clk_i);
        chk("lk_err",     64'(bus.req_err_o), 64'd1);
        chk("lk_sel_err", bus.biu_adri_o,     A_I);
        tick();
        drv(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("lk_sel_after_err", bus.biu_adri_o, A_I);
        tick();
        drv(2'b11, 2'b00, 1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("unlk_stb_ack", 64'(bus.req_stb_ack_o), 64'd1);
        chk("unlk_lock_o",  64'(bus.biu_lock_o),    64'd0);
        tick();
        drv(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("unlk_sel_data", bus.biu_adri_o,     A_D);
        chk("cnt1_biu_stb",  64'(bus.biu_stb_o), 64'd1);
        tick();

        // fill to DEPTH, then push and pop in the same cycle
        drv(2'b10, 2'b00, 1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("fill_stb_ack", 64'(bus.req_stb_ack_o), 64'd2);
        tick();
        drv(2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("full_biu_stb", 64'(bus.biu_stb_o), 64'd0);
        tick();
        drv(2'b10, 2'b00, 1'b1, 1'b1, 1'b0);
        @(negedge clk_i);
        chk("pp_ack",     64'(bus.req_ack_o),     64'd1);
        chk("pp_stb_ack", 64'(bus.req_stb_ack_o), 64'd2);
        tick();
        drv(2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("pp_still_full", 64'(bus.biu_stb_o), 64'd0);
        tick();
        drv(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        @(negedge clk_i);
        chk("drain1_ack", 64'(bus.req_ack_o), 64'd2);
        tick();
        @(negedge clk_i);
        chk("drain2_ack", 64'(bus.req_ack_o), 64'd2);
        tick();
        drv(2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("empty_biu_stb", 64'(bus.biu_stb_o), 64'd1);
        tick();

        // instr then data accepted; err for instr, ack for data
        drv(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("o_i_stb_ack", 64'(bus.req_stb_ack_o), 64'd1);
        tick();
        drv(2'b10, 2'b00, 1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("o_d_stb_ack", 64'(bus.req_stb_ack_o), 64'd2);
        tick();
        drv(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        @(negedge clk_i);
        chk("o_err",       64'(bus.req_err_o), 64'd1);
        chk("o_err_noack", 64'(bus.req_ack_o), 64'd0);
        tick();
        drv(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        @(negedge clk_i);
        chk("o_ack",       64'(bus.req_ack_o), 64'd2);
        chk("o_ack_noerr", 64'(bus.req_err_o), 64'd0);
        tick();
        drv(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        @(negedge clk_i);
        chk("o_spur_err",  64'(bus.spurious_o), 64'd1);
        chk("o_spur_noer", 64'(bus.req_err_o),  64'd0);
        tick();

        // starvation: instruction unacked while data wins, then instruction granted
        drv(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk($sformatf("starv_data_%0d", i), bus.biu_adri_o, A_D);
            tick();
        end
        tick();
        drv(2'b11, 2'b00, 1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("starv_grant_ack",  64'(bus.req_stb_ack_o), 64'd1);
        chk("starv_grant_adri", bus.biu_adri_o,         A_I);
        tick();
        drv(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("starv_cleared", bus.biu_adri_o, A_D);
        tick();
        drv(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        @(negedge clk_i);
        chk("starv_rsp_ack", 64'(bus.req_ack_o), 64'd1);
        tick();

        // reset with a transfer outstanding discards it
        drv(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("mid_stb_ack", 64'(bus.req_stb_ack_o), 64'd1);
        tick();
        drv(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("mid_rst_biu_stb", 64'(bus.biu_stb_o),  64'd0);
        chk("mid_rst_spur",    64'(bus.spurious_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        drv(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        @(negedge clk_i);
        chk("post_rst_spur", 64'(bus.spurious_o), 64'd1);
        chk("post_rst_ack",  64'(bus.req_ack_o),  64'd0);
        tick();
        drv(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
